gcd_job_scheduler: RTL and testbench

- Shares one GCD datapath core between N_REQ requesters. The core has a start/reset/Ain/Bin/Out/valid interface.
- Round-robin selection of pending jobs. The block launches the core, waits for its valid, and returns the result tagged with the requester id.
- Zero operands are bypassed, because the core never converges on them. A watchdog aborts jobs that do not finish.
- Sits between requester agents and a gcd core instance, in the same clock domain.

---
 rtl/gcd_sched_pkg.sv | 21 ++
 rtl/gcd_job_scheduler_if.sv | 32 +++
 rtl/gcd_rr_arb.sv | 41 ++++
 rtl/gcd_job_scheduler.sv | 141 ++++++++++++++
 tb/tb_gcd_job_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_sched_pkg.sv
// Shared definitions for the GCD job scheduler.
//   state_t   : scheduler FSM states
//   DEFAULT_W : default operand/result width (must match the GCD core)
//   id_width  : width of an encoded requester id for a given requester count
package gcd_sched_pkg;

  localparam int DEFAULT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  // A single requester still gets a 1-bit id so ports never collapse to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_job_scheduler_if.sv
// Bus between the scheduler and one GCD datapath core.
//   core_start : load strobe, operands valid on core_ain/core_bin
//   core_reset : clears the core
//   core_ain   : operand A
//   core_bin   : operand B
//   core_out   : core result
//   core_valid : result valid
// Modports: master = scheduler side, slave = core side.
interface gcd_job_scheduler_if
  import gcd_sched_pkg::*;
#(
  parameter int W = DEFAULT_W
);

  logic         core_start;
  logic         core_reset;
  logic [W-1:0] core_ain;
  logic [W-1:0] core_bin;
  logic [W-1:0] core_out;
  logic         core_valid;

  modport master (
    output core_start, core_reset, core_ain, core_bin,
    input  core_out, core_valid
  );

  modport slave (
    input  core_start, core_reset, core_ain, core_bin,
    output core_out, core_valid
  );

endinterface

// File: rtl/gcd_rr_arb.sv
// Combinational round-robin pick among pending requests.
//   req    : request vector
//   rr_ptr : index with highest priority this cycle; search wraps N_REQ-1 -> 0
//   grant  : one-hot grant (all zero when nothing is pending)
//   winner : encoded index of the granted request
//   any    : at least one request is pending
module gcd_rr_arb
  import gcd_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   winner,
  output logic             any
);

  int idx;

  // NOTE: every output of this block is given a default before the loop, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    // Walk from the farthest slot back towards rr_ptr; the last hit is the
    // closest to rr_ptr in wrap order and therefore wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req[idx]) begin
        winner = IDW'(idx);
        any    = 1'b1;
      end
    end
    if (any) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Shares one GCD core between N_REQ requesters, one job in flight at a time.
//   clk, reset  : clock, synchronous active-high reset
//   req         : per-requester request, held with operands until acked
//   ain, bin    : flattened operands, slice i belongs to requester i
//   ack         : one-cycle one-hot pulse, job accepted and operands latched
//   rsp_valid   : response available, held until rsp_ready
//   rsp_ready   : consumer accepts the response
//   rsp_id      : requester that owns the response
//   rsp_data    : GCD result (0 on watchdog abort)
//   rsp_err     : watchdog abort
//   core        : master side of the core bus
// Jobs with a zero operand never reach the core (it would not converge); the
// answer is A|B. Core jobs are aborted after MAX_CYCLES cycles in WAIT.
module gcd_job_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int W          = DEFAULT_W,
  parameter int MAX_CYCLES = 160,
  localparam int IDW       = id_width(N_REQ),
  localparam int WDW       = $clog2(MAX_CYCLES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*W-1:0]     ain,
  input  logic [N_REQ*W-1:0]     bin,
  output logic [N_REQ-1:0]       ack,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [W-1:0]           rsp_data,
  output logic                   rsp_err,
  gcd_job_scheduler_if.master    core
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [WDW-1:0]   wdog;
  logic             start_q;
  logic             abort_q;
  logic [W-1:0]     ain_q;
  logic [W-1:0]     bin_q;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   winner;
  logic             any;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  gcd_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  assign sel_a = ain[int'(winner)*W +: W];
  assign sel_b = bin[int'(winner)*W +: W];

  // Acceptance is decided in the same cycle the request is seen in IDLE;
  // suppressed under reset because the state update will not happen.
  assign ack = (state == IDLE && !reset) ? grant : '0;

  assign core.core_start = start_q;
  assign core.core_reset = reset | abort_q;
  assign core.core_ain   = ain_q;
  assign core.core_bin   = bin_q;

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      wdog      <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      ain_q     <= '0;
      bin_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            rsp_id  <= winner;
            rsp_err <= 1'b0;
            rr_ptr  <= (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);
            if (sel_a == '0 || sel_b == '0) begin
              // gcd(0,x) = x and gcd(0,0) = 0 are both A|B.
              rsp_data  <= sel_a | sel_b;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              // Operands stay on the core bus until the next launch.
              ain_q   <= sel_a;
              bin_q   <= sel_b;
              start_q <= 1'b1;
              state   <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (core.core_valid) begin
            rsp_data  <= core.core_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wdog == WDW'(MAX_CYCLES - 1)) begin
            // Resetting the core also discards any late valid it might raise.
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            abort_q   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Self-checking bench for gcd_job_scheduler: a behavioural GCD core stub, a
// driver issuing jobs, and a monitor that predicts acks and responses from
// plain arithmetic and compares them with a scoreboard queue.
module tb_gcd_job_scheduler;

  localparam int N_REQ      = 4;
  localparam int W          = 6;
  localparam int MAX_CYCLES = 160;
  localparam int IDW        = gcd_sched_pkg::id_width(N_REQ);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   ain;
  logic [N_REQ*W-1:0]   bin;
  logic [N_REQ-1:0]     ack;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_data;
  logic                 rsp_err;

  gcd_job_scheduler_if #(.W(W)) core_if ();

  gcd_job_scheduler #(.N_REQ(N_REQ), .W(W), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ain       (ain),
    .bin       (bin),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .core      (core_if)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- core stub
  // Loads on start, then one subtract step per cycle; valid once A==B.
  // core_hang freezes it so the watchdog path can be exercised.
  logic [W-1:0] c_a, c_b;
  logic         c_busy, c_valid;
  logic         core_hang;

  always @(posedge clk) begin
    if (core_if.core_reset) begin
      c_a <= '0; c_b <= '0; c_busy <= 1'b0; c_valid <= 1'b0;
    end else if (core_if.core_start) begin
      c_a <= core_if.core_ain; c_b <= core_if.core_bin;
      c_busy <= 1'b1; c_valid <= 1'b0;
    end else if (c_busy && !core_hang) begin
      if (c_a == c_b) begin
        c_valid <= 1'b1; c_busy <= 1'b0;
      end else if (c_a > c_b) begin
        c_a <= c_a - c_b;
      end else begin
        c_b <= c_b - c_a;
      end
    end
  end

  assign core_if.core_out   = c_a;
  assign core_if.core_valid = c_valid;

  // ---------------------------------------------------------------- checking
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: Euclid by remainder; covers the zero-operand cases too.
  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtract steps the core needs (k in the latency rule 4+k).
  function automatic int core_steps(input int a, input int b);
    int k = 0;
    while (a != b) begin
      if (a > b) a = a - b;
      else       b = b - a;
      k++;
    end
    return k;
  endfunction

  typedef struct {
    int id;
    int data;
    bit err;
    int lat;
    int ack_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   ack_log[$];

  // ---------------------------------------------------------------- monitor
  int   cyc = 0;
  int   m_rr = 0;
  int   m_w, m_a, m_b;
  int   core_start_cnt = 0;
  int   core_reset_cnt = 0;
  int   last_ack_cyc = -1;
  int   last_hs_cyc = -1;
  bit   in_rsp = 1'b0;
  bit   cur_ok = 1'b0;
  exp_t m_e;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        m_rr   = 0;
        in_rsp = 1'b0;
        exp_q.delete();
      end else begin
        core_start_cnt += int'(core_if.core_start);
        core_reset_cnt += int'(core_if.core_reset);

        if (ack != '0) begin
          m_w = -1;
          for (int k = 0; k < N_REQ; k++)
            if (m_w < 0 && req[(m_rr + k) % N_REQ]) m_w = (m_rr + k) % N_REQ;
          check("ack_grant", ack, (m_w < 0) ? 0 : (1 << m_w));
          check("ack_during_rsp", rsp_valid, 0);
          if (m_w >= 0) begin
            m_a = int'(ain[m_w*W +: W]);
            m_b = int'(bin[m_w*W +: W]);
            m_e.id      = m_w;
            m_e.ack_cyc = cyc;
            if (m_a == 0 || m_b == 0) begin
              m_e.data = gcd_ref(m_a, m_b); m_e.err = 1'b0; m_e.lat = 1;
            end else if (core_hang) begin
              m_e.data = 0; m_e.err = 1'b1; m_e.lat = 2 + MAX_CYCLES;
            end else begin
              m_e.data = gcd_ref(m_a, m_b); m_e.err = 1'b0; m_e.lat = 4 + core_steps(m_a, m_b);
            end
            exp_q.push_back(m_e);
            ack_log.push_back(m_w);
            m_rr = (m_w + 1) % N_REQ;
            last_ack_cyc = cyc;
          end
        end

        if (rsp_valid) begin
          if (!in_rsp) begin
            check("rsp_pending_job", exp_q.size() > 0, 1);
            cur_ok = exp_q.size() > 0;
            if (cur_ok) begin
              cur = exp_q.pop_front();
              check("rsp_id", rsp_id, cur.id);
              check("rsp_data", rsp_data, cur.data);
              check("rsp_err", rsp_err, cur.err);
              check("rsp_latency", cyc - cur.ack_cyc, cur.lat);
            end
            in_rsp = 1'b1;
          end else if (cur_ok) begin
            check("rsp_hold_id", rsp_id, cur.id);
            check("rsp_hold_data", rsp_data, cur.data);
            check("rsp_hold_err", rsp_err, cur.err);
          end
          if (rsp_ready) begin
            in_rsp = 1'b0;
            last_hs_cyc = cyc;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  bit rand_ready = 1'b0;

  // One clock: sample ack mid-cycle, then drop acked requests just after the edge.
  task automatic tick();
    logic [N_REQ-1:0] a_s;
    @(negedge clk);
    a_s = ack;
    @(posedge clk);
    #1;
    req = req & ~a_s;
    if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic post(input int id, input int a, input int b);
    req[id]         = 1'b1;
    ain[id*W +: W]  = W'(a);
    bin[id*W +: W]  = W'(b);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((req != '0 || exp_q.size() != 0 || rsp_valid) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_completed"}, n < budget, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_core_start"}, core_if.core_start, 0);
    check({tag, "_core_ain"}, core_if.core_ain, 0);
    check({tag, "_core_bin"}, core_if.core_bin, 0);
    check({tag, "_core_reset"}, core_if.core_reset, 1);
  endtask

  // Assert reset for two edges, check outputs while it is held, release.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int n;
    int sc;
    int rc;
    int posted;

    reset = 1'b1; req = '0; ain = '0; bin = '0;
    rsp_ready = 1'b0; core_hang = 1'b0;
    @(posedge clk);
    #1;
    apply_reset("rst");
    rsp_ready = 1'b1;

    // Single core job: 12,8 -> 4 after two core steps.
    post(1, 12, 8);
    drain("single", 40);

    // Zero-operand bypass never touches the core.
    sc = core_start_cnt;
    post(0, 0, 9);
    drain("bypass_0_9", 10);
    post(0, 0, 0);
    drain("bypass_0_0", 10);
    check("bypass_core_start", core_start_cnt - sc, 0);

    // Full contention from rr_ptr=0: order 0,1,2,3,0.
    apply_reset("rst_rr");
    ack_log.delete();
    for (int i = 0; i < N_REQ; i++) post(i, 6, 6);
    n = 0;
    while (req[0] && n < 20) begin tick(); n++; end
    check("rr_first_ack_seen", req[0], 0);
    post(0, 6, 6);
    drain("rotation", 200);
    check("rr_ack_count", ack_log.size(), 5);
    for (int i = 0; i < 5 && i < ack_log.size(); i++)
      check($sformatf("rr_order_%0d", i), ack_log[i], exp_order[i]);

    // Stuck core: watchdog abort, single core_reset pulse, then normal job.
    core_hang = 1'b1;
    rc = core_reset_cnt;
    post(2, 9, 6);
    drain("watchdog", MAX_CYCLES + 40);
    check("watchdog_core_reset_pulses", core_reset_cnt - rc, 1);
    core_hang = 1'b0;
    post(2, 9, 6);
    drain("after_watchdog", 40);

    // Back-pressure: response held while rsp_ready is low, pending req waits.
    rsp_ready = 1'b0;
    post(3, 21, 14);
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("bp_rsp_seen", rsp_valid, 1);
    post(1, 5, 5);
    repeat (10) tick();
    check("bp_no_ack_while_held", req[1], 1);
    rsp_ready = 1'b1;
    n = 0;
    while (req[1] && n < 20) begin tick(); n++; end
    check("bp_ack_after_handshake", last_ack_cyc - last_hs_cyc, 1);
    drain("backpressure", 40);

    // Reset during WAIT drops the job; the next job works.
    post(0, 63, 1);
    repeat (6) tick();
    apply_reset("rst_mid");
    repeat (3) tick();
    check("rst_mid_no_rsp", rsp_valid, 0);
    post(2, 10, 4);
    drain("after_reset", 40);

    // Randomized mix with random back-pressure.
    rand_ready = 1'b1;
    posted = 0;
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] && posted < 40 && $urandom_range(0, 7) == 0) begin
          post(i,
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
               ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)));
          posted++;
        end
      end
      tick();
    end
    drain("random", 8000);
    rand_ready = 1'b0;
    rsp_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
